// File: rtl/mult_div_unit_pkg.sv
// Shared MD-unit definitions: operation encodings and the control state type.
// The op encodings must stay aligned with the main decoder and the hazard unit.
package mult_div_unit_pkg;

    localparam int unsigned MD_W = 32;

    typedef enum logic [3:0] {
        MDOP_NONE  = 4'd0,
        MDOP_MULT  = 4'd1,
        MDOP_MULTU = 4'd2,
        MDOP_DIV   = 4'd3,
        MDOP_DIVU  = 4'd4,
        MDOP_MTHI  = 4'd5,
        MDOP_MTLO  = 4'd6,
        MDOP_MFHI  = 4'd7,
        MDOP_MFLO  = 4'd8
    } md_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } md_state_e;

    function automatic logic is_md_start(input logic [3:0] op);
        return (op == MDOP_MULT) || (op == MDOP_MULTU) ||
               (op == MDOP_DIV)  || (op == MDOP_DIVU);
    endfunction

endpackage

// File: rtl/mult_div_unit_md_arith.sv
// Combinational arithmetic core: produces the full {hi,lo} result of one MD op.
// A single unsigned divider serves both div (on magnitudes) and divu.
module md_arith
    import mult_div_unit_pkg::*;
(
    input  logic [3:0]  op_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic [63:0] result_o,
    output logic        div_by_zero_o
);

    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [31:0] den_safe;
    logic [31:0] num;
    logic [31:0] den;
    logic [31:0] quo;
    logic [31:0] rem;
    logic [31:0] quo_s;
    logic [31:0] rem_s;
    logic        is_div;
    logic        is_divu;

    assign is_div  = (op_i == MDOP_DIV);
    assign is_divu = (op_i == MDOP_DIVU);

    assign prod_s = $signed({{32{a_i[31]}}, a_i}) * $signed({{32{b_i[31]}}, b_i});
    assign prod_u = {32'd0, a_i} * {32'd0, b_i};

    // A zero divisor is replaced by 1 so the divider never sees 0; the result is discarded anyway.
    assign den_safe = (b_i == '0) ? 32'd1 : b_i;
    assign mag_a    = a_i[31] ? (~a_i + 32'd1) : a_i;
    assign mag_b    = den_safe[31] ? (~den_safe + 32'd1) : den_safe;

    assign num = is_div ? mag_a : a_i;
    assign den = is_div ? mag_b : den_safe;
    assign quo = num / den;
    assign rem = num % den;

    // Quotient truncates toward zero; remainder follows the dividend's sign.
    assign quo_s = (a_i[31] ^ b_i[31]) ? (~quo + 32'd1) : quo;
    assign rem_s = a_i[31] ? (~rem + 32'd1) : rem;

    always_comb begin
        result_o = '0;
        case (op_i)
            MDOP_MULT:  result_o = prod_s;
            MDOP_MULTU: result_o = prod_u;
            MDOP_DIV:   result_o = {rem_s, quo_s};
            MDOP_DIVU:  result_o = {rem, quo};
            default:    result_o = '0;
        endcase
    end

    assign div_by_zero_o = (is_div || is_divu) && (b_i == '0);

endmodule

// File: rtl/mult_div_unit.sv
// E-stage multiply/divide unit: owns HI/LO, models fixed mult/div latency and drives busy.
// The result is computed at issue and held in a pending register until the commit edge.
module mult_div_unit
    import mult_div_unit_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  iMDop,
    input  logic [31:0] iA,
    input  logic [31:0] iB,
    output logic        oMDbusy,
    output logic [31:0] oMDout,
    output logic [31:0] oHI,
    output logic [31:0] oLO
);

    localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

    md_state_e          state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [63:0]        pend_q, pend_d;
    logic               pend_wr_q, pend_wr_d;
    logic [31:0]        hi_q, hi_d;
    logic [31:0]        lo_q, lo_d;

    logic [63:0]        arith_res;
    logic               arith_dbz;
    logic               start;
    logic               is_mult_op;

    md_arith u_md_arith (
        .op_i          (iMDop),
        .a_i           (iA),
        .b_i           (iB),
        .result_o      (arith_res),
        .div_by_zero_o (arith_dbz)
    );

    assign start      = (state_q == ST_IDLE) && is_md_start(iMDop);
    assign is_mult_op = (iMDop == MDOP_MULT) || (iMDop == MDOP_MULTU);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            pend_q    <= '0;
            pend_wr_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pend_q    <= pend_d;
            pend_wr_q <= pend_wr_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pend_d    = pend_q;
        pend_wr_d = pend_wr_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    pend_d    = arith_res;
                    pend_wr_d = !arith_dbz;
                    cnt_d     = is_mult_op ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
                    state_d   = ST_BUSY;
                end else if (iMDop == MDOP_MTHI) begin
                    hi_d = iA;
                end else if (iMDop == MDOP_MTLO) begin
                    lo_d = iA;
                end
            end
            ST_BUSY: begin
                // Divide-by-zero still runs the full period but leaves HI/LO untouched.
                if (cnt_q == CNT_W'(1)) begin
                    if (pend_wr_q) begin
                        hi_d = pend_q[63:32];
                        lo_d = pend_q[31:0];
                    end
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        oMDout = '0;
        if (iMDop == MDOP_MFHI) begin
            oMDout = hi_q;
        end else if (iMDop == MDOP_MFLO) begin
            oMDout = lo_q;
        end
    end

    assign oMDbusy = start || (cnt_q != '0);
    assign oHI     = hi_q;
    assign oLO     = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed scenarios plus randomized ops
// checked against a plain-arithmetic HI/LO model.
module tb_mult_div_unit;

    localparam int MC = 5;
    localparam int DC = 10;

    localparam logic [3:0] OP_NONE  = 4'd0;
    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
    localparam logic [3:0] OP_MFHI  = 4'd7;
    localparam logic [3:0] OP_MFLO  = 4'd8;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  iMDop;
    logic [31:0] iA;
    logic [31:0] iB;
    logic        oMDbusy;
    logic [31:0] oMDout;
    logic [31:0] oHI;
    logic [31:0] oLO;

    int checks = 0;
    int errors = 0;
    logic [31:0] hi_m, lo_m;

    mult_div_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk     (clk),
        .reset   (reset),
        .iMDop   (iMDop),
        .iA      (iA),
        .iB      (iB),
        .oMDbusy (oMDbusy),
        .oMDout  (oMDout),
        .oHI     (oHI),
        .oLO     (oLO)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        iMDop = op;
        iA    = a;
        iB    = b;
        #1;
    endtask

    // Reference: what HI/LO hold after the op completes, from plain integer arithmetic.
    task automatic ref_md(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] hi_in, input logic [31:0] lo_in,
                          output logic [31:0] hi_out, output logic [31:0] lo_out);
        longint      sa, sb, sp, sq, sr;
        logic [63:0] up;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        hi_out = hi_in;
        lo_out = lo_in;
        case (op)
            OP_MULT: begin
                sp = sa * sb;
                up = sp;
                hi_out = up[63:32];
                lo_out = up[31:0];
            end
            OP_MULTU: begin
                up = {32'd0, a} * {32'd0, b};
                hi_out = up[63:32];
                lo_out = up[31:0];
            end
            OP_DIV: if (b != 0) begin
                sq = sa / sb;
                sr = sa % sb;
                up = sq; lo_out = up[31:0];
                up = sr; hi_out = up[31:0];
            end
            OP_DIVU: if (b != 0) begin
                lo_out = a / b;
                hi_out = a % b;
            end
            OP_MTHI: hi_out = a;
            OP_MTLO: lo_out = a;
            default: ;
        endcase
    endtask

    // Issues one start op and observes busy over cycles 0..lat+1; returns the first wrong cycle or -1.
    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int lat, output int busy_bad);
        busy_bad = -1;
        cyc();
        drive(op, a, b);
        if (oMDbusy !== 1'b1 && busy_bad < 0) busy_bad = 0;
        for (int k = 1; k <= lat; k++) begin
            cyc();
            drive(OP_NONE, '0, '0);
            if (oMDbusy !== 1'b1 && busy_bad < 0) busy_bad = k;
        end
        cyc();
        drive(OP_NONE, '0, '0);
        if (oMDbusy !== 1'b0 && busy_bad < 0) busy_bad = lat + 1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(OP_NONE, '0, '0);
        cyc();
        cyc();
        checks++; if (oMDbusy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", oMDbusy); end
        checks++; if (oMDout !== 32'h0) begin errors++; $display("FAIL reset_out got %h exp 0", oMDout); end
        checks++; if (oHI !== 32'h0) begin errors++; $display("FAIL reset_hi got %h exp 0", oHI); end
        checks++; if (oLO !== 32'h0) begin errors++; $display("FAIL reset_lo got %h exp 0", oLO); end
        reset = 1'b0;
        hi_m = '0;
        lo_m = '0;
    endtask

    task automatic test_mult();
        int bb;
        run_op(OP_MULT, 32'hFFFFFFFF, 32'h2, MC, bb);
        checks++; if (bb != -1) begin errors++; $display("FAIL mult_busy wrong at cycle %0d exp none", bb); end
        checks++; if (oHI !== 32'hFFFFFFFF) begin errors++; $display("FAIL mult_hi got %h exp ffffffff", oHI); end
        checks++; if (oLO !== 32'hFFFFFFFE) begin errors++; $display("FAIL mult_lo got %h exp fffffffe", oLO); end

        cyc();
        drive(OP_MULTU, 32'hFFFFFFFF, 32'h2);
        checks++; if (oMDbusy !== 1'b1) begin errors++; $display("FAIL multu_busy0 got %b exp 1", oMDbusy); end
        for (int k = 1; k <= MC; k++) begin
            cyc();
            drive((k == 2) ? OP_MFHI : (k == 3) ? OP_MFLO : OP_NONE, '0, '0);
            checks++; if (oMDbusy !== 1'b1) begin errors++; $display("FAIL multu_busy cycle %0d got %b exp 1", k, oMDbusy); end
            if (k == 2) begin
                checks++; if (oMDout !== 32'hFFFFFFFF) begin errors++; $display("FAIL multu_old_hi got %h exp ffffffff", oMDout); end
            end
            if (k == 3) begin
                checks++; if (oMDout !== 32'hFFFFFFFE) begin errors++; $display("FAIL multu_old_lo got %h exp fffffffe", oMDout); end
            end
        end
        cyc();
        drive(OP_NONE, '0, '0);
        checks++; if (oMDbusy !== 1'b0) begin errors++; $display("FAIL multu_idle got %b exp 0", oMDbusy); end
        checks++; if (oHI !== 32'h1) begin errors++; $display("FAIL multu_hi got %h exp 00000001", oHI); end
        checks++; if (oLO !== 32'hFFFFFFFE) begin errors++; $display("FAIL multu_lo got %h exp fffffffe", oLO); end
        hi_m = 32'h1;
        lo_m = 32'hFFFFFFFE;
    endtask

    task automatic test_div();
        int bb;
        run_op(OP_DIV, 32'hFFFFFFF9, 32'h2, DC, bb);
        checks++; if (bb != -1) begin errors++; $display("FAIL div_busy wrong at cycle %0d exp none", bb); end
        checks++; if (oLO !== 32'hFFFFFFFD) begin errors++; $display("FAIL div_lo got %h exp fffffffd", oLO); end
        checks++; if (oHI !== 32'hFFFFFFFF) begin errors++; $display("FAIL div_hi got %h exp ffffffff", oHI); end
        run_op(OP_DIV, 32'h80000000, 32'hFFFFFFFF, DC, bb);
        checks++; if (bb != -1) begin errors++; $display("FAIL ovf_busy wrong at cycle %0d exp none", bb); end
        checks++; if (oLO !== 32'h80000000) begin errors++; $display("FAIL ovf_lo got %h exp 80000000", oLO); end
        checks++; if (oHI !== 32'h0) begin errors++; $display("FAIL ovf_hi got %h exp 00000000", oHI); end
        run_op(OP_DIVU, 32'd100, 32'd7, DC, bb);
        checks++; if (oLO !== 32'd14 || oHI !== 32'd2) begin errors++; $display("FAIL divu_res got %h_%h exp 00000002_0000000e", oHI, oLO); end
        hi_m = 32'd2;
        lo_m = 32'd14;
    endtask

    task automatic test_div_zero();
        int bb;
        cyc();
        drive(OP_MTHI, 32'h11111111, '0);
        checks++; if (oMDbusy !== 1'b0) begin errors++; $display("FAIL mthi_busy got %b exp 0", oMDbusy); end
        cyc();
        drive(OP_MTLO, 32'h22222222, '0);
        checks++; if (oHI !== 32'h11111111) begin errors++; $display("FAIL mthi_val got %h exp 11111111", oHI); end
        cyc();
        drive(OP_NONE, '0, '0);
        checks++; if (oLO !== 32'h22222222) begin errors++; $display("FAIL mtlo_val got %h exp 22222222", oLO); end
        run_op(OP_DIVU, 32'd7, 32'd0, DC, bb);
        checks++; if (bb != -1) begin errors++; $display("FAIL dz_busy wrong at cycle %0d exp none", bb); end
        checks++; if (oHI !== 32'h11111111 || oLO !== 32'h22222222) begin errors++; $display("FAIL dz_keep got %h_%h exp 11111111_22222222", oHI, oLO); end
        run_op(OP_DIV, 32'hFFFFFF00, 32'd0, DC, bb);
        checks++; if (bb != -1 || oHI !== 32'h11111111 || oLO !== 32'h22222222) begin errors++; $display("FAIL dz_signed got %h_%h bb %0d exp 11111111_22222222", oHI, oLO, bb); end
        hi_m = 32'h11111111;
        lo_m = 32'h22222222;
    endtask

    task automatic test_ignored();
        cyc();
        drive(OP_MULT, 32'd3, 32'd4);
        for (int k = 1; k <= MC; k++) begin
            cyc();
            drive((k == 2) ? OP_MTHI : (k == 4) ? OP_MULTU : OP_NONE, 32'h0000AAAA, 32'd5);
            checks++; if (oMDbusy !== 1'b1) begin errors++; $display("FAIL ign_busy cycle %0d got %b exp 1", k, oMDbusy); end
        end
        cyc();
        drive(OP_NONE, '0, '0);
        checks++; if (oMDbusy !== 1'b0) begin errors++; $display("FAIL ign_idle got %b exp 0", oMDbusy); end
        checks++; if (oHI !== 32'h0 || oLO !== 32'd12) begin errors++; $display("FAIL ign_res got %h_%h exp 00000000_0000000c", oHI, oLO); end
        cyc();
        drive(OP_MTHI, 32'h0000AAAA, '0);
        checks++; if (oMDbusy !== 1'b0) begin errors++; $display("FAIL mthi_idle_busy got %b exp 0", oMDbusy); end
        cyc();
        drive(OP_MFHI, '0, '0);
        checks++; if (oMDout !== 32'h0000AAAA) begin errors++; $display("FAIL mfhi_after got %h exp 0000aaaa", oMDout); end
        drive(4'hF, 32'h12345678, '0);
        checks++; if (oMDout !== 32'h0) begin errors++; $display("FAIL unknown_op_out got %h exp 0", oMDout); end
        cyc();
        drive(OP_NONE, '0, '0);
        checks++; if (oHI !== 32'h0000AAAA || oLO !== 32'd12 || oMDbusy !== 1'b0) begin errors++; $display("FAIL unknown_op_state got %h_%h busy %b exp 0000aaaa_0000000c 0", oHI, oLO, oMDbusy); end
        hi_m = 32'h0000AAAA;
        lo_m = 32'd12;
    endtask

    task automatic test_reset_mid();
        cyc();
        drive(OP_MULT, 32'd7, 32'd9);
        cyc();
        drive(OP_NONE, '0, '0);
        cyc();
        cyc();
        reset = 1'b1;
        cyc();
        checks++; if (oMDbusy !== 1'b0) begin errors++; $display("FAIL rmid_busy got %b exp 0", oMDbusy); end
        checks++; if (oHI !== 32'h0 || oLO !== 32'h0) begin errors++; $display("FAIL rmid_regs got %h_%h exp 0_0", oHI, oLO); end
        reset = 1'b0;
        for (int k = 0; k < 4; k++) cyc();
        checks++; if (oHI !== 32'h0 || oLO !== 32'h0 || oMDbusy !== 1'b0) begin errors++; $display("FAIL rmid_nocommit got %h_%h busy %b exp 0_0 0", oHI, oLO, oMDbusy); end
        hi_m = '0;
        lo_m = '0;
    endtask

    task automatic test_random();
        logic [3:0]  op;
        logic [31:0] a, b, eh, el;
        int          bb, lat;
        for (int it = 0; it < 30; it++) begin
            op = 4'($urandom_range(1, 6));
            a  = $urandom;
            b  = $urandom;
            if ($urandom_range(0, 3) == 0) b = b >> $urandom_range(16, 31);
            if ((op == OP_DIV || op == OP_DIVU) && $urandom_range(0, 4) == 0) b = '0;
            if (op == OP_DIV && $urandom_range(0, 5) == 0) begin a = 32'h80000000; b = 32'hFFFFFFFF; end
            ref_md(op, a, b, hi_m, lo_m, eh, el);
            if (op == OP_MTHI || op == OP_MTLO) begin
                cyc();
                drive(op, a, b);
                checks++; if (oMDbusy !== 1'b0) begin errors++; $display("FAIL rnd_move_busy it %0d got %b exp 0", it, oMDbusy); end
                cyc();
                drive(OP_NONE, '0, '0);
            end else begin
                lat = (op == OP_MULT || op == OP_MULTU) ? MC : DC;
                run_op(op, a, b, lat, bb);
                checks++; if (bb != -1) begin errors++; $display("FAIL rnd_busy it %0d op %0d wrong at cycle %0d exp none", it, op, bb); end
            end
            hi_m = eh;
            lo_m = el;
            drive(OP_MFHI, '0, '0);
            checks++; if (oMDout !== hi_m) begin errors++; $display("FAIL rnd_hi it %0d op %0d a %h b %h got %h exp %h", it, op, a, b, oMDout, hi_m); end
            drive(OP_MFLO, '0, '0);
            checks++; if (oMDout !== lo_m) begin errors++; $display("FAIL rnd_lo it %0d op %0d a %h b %h got %h exp %h", it, op, a, b, oMDout, lo_m); end
            drive(OP_NONE, '0, '0);
        end
    endtask

    initial begin
        reset = 1'b1;
        iMDop = OP_NONE;
        iA    = '0;
        iB    = '0;
        hi_m  = '0;
        lo_m  = '0;
        test_reset();
        test_mult();
        test_div();
        test_div_zero();
        test_ignored();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
